// File: rtl/flasher_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : flasher_sequencer
// Description : Sequences a batch of runs on an external LED flasher. Each
//               run fires a one-cycle trigger, waits for the flasher to light
//               up, follows its LED vector until it has gone fully lit and
//               back to dark, then idles for a programmable gap before the
//               next run. Start-up timeout and per-run watchdog fall into a
//               sticky error state; STOP ends the batch at a run boundary.
// Ports       : clk          - sole clock, rising edge
//               rst_n        - asynchronous active-low reset
//               start        - level, requests a batch
//               stop         - level, aborts/finishes the batch
//               repeat_count - runs per batch, latched on accepted start
//               idle_gap     - idle cycles between runs, latched on start
//               led_in       - LED vector returned by the flasher
//               flick_out    - one-cycle trigger to the flasher
//               busy         - high in every state except IDLE and ERR
//               done         - one-cycle pulse when a batch completes
//               err          - sticky error flag
//               run_cnt      - completed runs in the current batch
// Revision    : 1.0 - initial release
// ============================================================================
module flasher_sequencer #(
    parameter int unsigned START_TO = 4,
    parameter int unsigned WDOG_MAX = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [3:0]  repeat_count,
    input  logic [7:0]  idle_gap,
    input  logic [15:0] led_in,
    output logic        flick_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  run_cnt
);

    // Counters only need to reach LIMIT-1; the transition fires on that value.
    localparam int unsigned c_WAIT_W = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam int unsigned c_WDOG_W = (WDOG_MAX > 1) ? $clog2(WDOG_MAX) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(START_TO - 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PULSE    = 3'd1,
        S_WAIT_ACT = 3'd2,
        S_RUN      = 3'd3,
        S_GAP      = 3'd4,
        S_FIN      = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [c_WDOG_W-1:0]   r_wdog_cnt;
    logic [7:0]            r_gap_cnt;
    logic [7:0]            r_gap;
    logic [3:0]            r_repeat;
    logic [3:0]            r_run_cnt;
    logic                  r_seen_full;
    logic                  r_stop_pending;
    logic                  r_flick;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_led_zero;
    logic                  w_led_full;
    logic                  w_run_done;
    logic [3:0]            w_cnt_inc;
    logic                  w_last_run;

    // A batch may only be launched from IDLE or ERR, with a nonzero run
    // count and without a simultaneous stop request.
    assign w_accept   = ((r_state == S_IDLE) || (r_state == S_ERR)) &&
                        start && !stop && (repeat_count != 4'd0);
    assign w_led_zero = (led_in == 16'h0000);
    assign w_led_full = (led_in == 16'hFFFF);
    // Dark only counts as the end of a run once the flasher has been fully
    // lit; an interim dark phase earlier in the run is ignored.
    assign w_run_done = r_seen_full && w_led_zero;
    assign w_cnt_inc  = (r_run_cnt == 4'd15) ? 4'd15 : r_run_cnt + 4'd1;
    // A stop seen in the completing cycle itself also ends the batch.
    assign w_last_run = (w_cnt_inc == r_repeat) || r_stop_pending || stop;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_ERR: begin
                if (w_accept) w_state_nxt = S_PULSE;
            end
            S_PULSE: begin
                w_state_nxt = S_WAIT_ACT;
            end
            S_WAIT_ACT: begin
                if (!w_led_zero)                   w_state_nxt = S_RUN;
                else if (r_wait_cnt == c_WAIT_LAST) w_state_nxt = S_ERR;
            end
            S_RUN: begin
                if (w_run_done) begin
                    if (w_last_run)          w_state_nxt = S_FIN;
                    else if (r_gap == 8'd0)  w_state_nxt = S_PULSE;
                    else                     w_state_nxt = S_GAP;
                end else if (r_wdog_cnt == c_WDOG_LAST) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_GAP: begin
                if (stop)                            w_state_nxt = S_FIN;
                else if (r_gap_cnt == r_gap - 8'd1)  w_state_nxt = S_PULSE;
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // aligned with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_wait_cnt     <= '0;
            r_wdog_cnt     <= '0;
            r_gap_cnt      <= '0;
            r_gap          <= '0;
            r_repeat       <= '0;
            r_run_cnt      <= '0;
            r_seen_full    <= 1'b0;
            r_stop_pending <= 1'b0;
            r_flick        <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_flick <= (w_state_nxt == S_PULSE);
            r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERR);
            r_done  <= (w_state_nxt == S_FIN);
            r_err   <= (w_state_nxt == S_ERR);

            // Each counter runs only while its own state is active and is
            // zero on entry to that state.
            r_wait_cnt <= (r_state == S_WAIT_ACT) ? r_wait_cnt + c_WAIT_W'(1) : '0;
            r_wdog_cnt <= (r_state == S_RUN)      ? r_wdog_cnt + c_WDOG_W'(1) : '0;
            r_gap_cnt  <= (r_state == S_GAP)      ? r_gap_cnt + 8'd1          : '0;
            r_seen_full <= (r_state == S_RUN) && (r_seen_full || w_led_full);

            if (w_accept) begin
                r_repeat       <= repeat_count;
                r_gap          <= idle_gap;
                r_run_cnt      <= 4'd0;
                r_stop_pending <= 1'b0;
            end else begin
                // A stop during trigger, start-up or run never cuts the run
                // short; it is remembered and applied at completion.
                if (stop && ((r_state == S_PULSE) || (r_state == S_WAIT_ACT) ||
                             (r_state == S_RUN))) begin
                    r_stop_pending <= 1'b1;
                end
                if ((r_state == S_RUN) && w_run_done) begin
                    r_run_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign flick_out = r_flick;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign run_cnt   = r_run_cnt;

endmodule
`default_nettype wire

// File: tb/tb_flasher_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_flasher_sequencer
// Description : Self-checking bench for flasher_sequencer. Stimulus pushes
//               expected output events (trigger, done, error rise, busy fall)
//               with their cycle and run count into a queue; a monitor pops
//               and compares whenever the DUT shows such an event. A small
//               flasher model answers each trigger with a scripted LED trace.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flasher_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [3:0]  repeat_count;
    logic [7:0]  idle_gap;
    logic [15:0] led_in;
    logic        flick_out;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  run_cnt;

    flasher_sequencer #(
        .START_TO (4),
        .WDOG_MAX (200)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .repeat_count (repeat_count),
        .idle_gap     (idle_gap),
        .led_in       (led_in),
        .flick_out    (flick_out),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .run_cnt      (run_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        byte kind;
        int  cyc;
        int  rc;
    } ev_t;

    ev_t exp_q[$];
    int  mode_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic push_ev(input byte k, input int c, input int rc);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.rc   = rc;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, expv);
    endtask

    // ---------------- monitor ----------------
    task automatic match_ev(input byte k);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL event: got %c at cycle %0d run_cnt %0d, required no event",
                     k, cyc, run_cnt);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.cyc == cyc && e.rc == int'(run_cnt)) n_pass++;
            else $display("FAIL event: got %c at cycle %0d run_cnt %0d, required %c at cycle %0d run_cnt %0d",
                          k, cyc, run_cnt, e.kind, e.cyc, e.rc);
        end
    endtask

    initial begin
        logic prev_busy;
        logic prev_err;
        ev_t  e;
        prev_busy = 1'b0;
        prev_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (flick_out)              match_ev("F");
            if (done)                   match_ev("D");
            if (err && !prev_err)       match_ev("E");
            if (!busy && prev_busy)     match_ev("B");
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                $display("FAIL event: got nothing, required %c at cycle %0d run_cnt %0d",
                         e.kind, e.cyc, e.rc);
            end
            prev_busy = busy;
            prev_err  = err;
        end
    end

    // ---------------- flasher model ----------------
    // mode 0: normal trace with an interim dark phase; 1: never lights;
    // 2: lights to 16'h001F and sticks there.
    initial begin
        logic [15:0] led_q[$];
        int m;
        led_in = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                led_q.delete();
                led_in = '0;
            end else begin
                if (flick_out) begin
                    m = (mode_q.size() > 0) ? mode_q.pop_front() : 0;
                    case (m)
                        1:       led_q = '{16'h0000};
                        2:       led_q = '{16'h0000, 16'h0000, 16'h001F};
                        default: led_q = '{16'h0000, 16'h0000, 16'h00FF, 16'h0000,
                                           16'h0FFF, 16'hFFFF, 16'h0000};
                    endcase
                end
                if (led_q.size() > 0) led_in = led_q.pop_front();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic launch(input int rep, input int gap);
        start        = 1'b1;
        repeat_count = 4'(rep);
        idle_gap     = 8'(gap);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            tick();
            n++;
        end
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else begin
            $display("FAIL %s: %0d expected events still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic single_batch(input string name);
        int s;
        s = cyc;
        launch(1, 0);
        push_ev("F", s + 1, 0);
        push_ev("D", s + 8, 1);
        push_ev("B", s + 9, 1);
        tick();
        start = 1'b0;
        drain(name);
    endtask

    initial begin
        int s;
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        repeat_count = '0;
        idle_gap = '0;

        // Reset state
        repeat (3) tick();
        check("reset_outputs", int'({flick_out, busy, done, err, run_cnt}), 0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_after_reset", int'({flick_out, busy, done, err, run_cnt}), 0);

        // One run, no gap
        single_batch("single_run");

        // Three runs, gap 10, start held high through the batch
        s = cyc;
        launch(3, 10);
        push_ev("F", s + 1, 0);
        push_ev("F", s + 18, 1);
        push_ev("F", s + 35, 2);
        push_ev("D", s + 42, 3);
        push_ev("B", s + 43, 3);
        wait_to(s + 40);
        start = 1'b0;
        drain("three_runs_gap10");

        // Flasher never lights: start-up timeout, then restart clears error
        mode_q.push_back(1);
        s = cyc;
        launch(2, 0);
        push_ev("F", s + 1, 0);
        push_ev("E", s + 6, 0);
        push_ev("B", s + 6, 0);
        tick();
        start = 1'b0;
        wait_to(s + 10);
        check("err_held", int'({err, busy}), 2);
        drain("start_timeout");
        single_batch("restart_after_err");

        // Second run sticks partially lit: watchdog error, run count kept
        mode_q.push_back(0);
        mode_q.push_back(2);
        s = cyc;
        launch(3, 0);
        push_ev("F", s + 1, 0);
        push_ev("F", s + 8, 1);
        push_ev("E", s + 211, 1);
        push_ev("B", s + 211, 1);
        tick();
        start = 1'b0;
        drain("watchdog");
        check("watchdog_run_cnt", int'(run_cnt), 1);

        // Stop during the second run of four: that run still completes
        s = cyc;
        launch(4, 3);
        push_ev("F", s + 1, 0);
        push_ev("F", s + 11, 1);
        push_ev("D", s + 18, 2);
        push_ev("B", s + 19, 2);
        tick();
        start = 1'b0;
        wait_to(s + 15);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain("stop_in_run");

        // Stop during the gap finishes the batch at once
        s = cyc;
        launch(3, 10);
        push_ev("F", s + 1, 0);
        push_ev("D", s + 11, 1);
        push_ev("B", s + 12, 1);
        tick();
        start = 1'b0;
        wait_to(s + 10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain("stop_in_gap");

        // Reset in the middle of the second run
        s = cyc;
        launch(3, 0);
        push_ev("F", s + 1, 0);
        push_ev("F", s + 8, 1);
        push_ev("B", s + 13, 0);
        tick();
        start = 1'b0;
        wait_to(s + 13);
        rst_n = 1'b0;
        #1;
        check("reset_mid_run", int'({flick_out, busy, done, err, run_cnt}), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        drain("reset_mid_run_events");
        single_batch("fresh_after_reset");

        // Ignored starts: zero repeat, and start together with stop
        launch(0, 0);
        tick();
        repeat_count = 4'd2;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        tick();
        tick();
        check("ignored_start", int'({busy, flick_out, err}), 0);
        drain("final_queue");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish within 200000 time units");
        $fatal(1);
    end

endmodule
`default_nettype wire
